// File: rtl/pwr_trans_acum_if.sv
// Event-in / dump-out bus for the power-transition accumulator bank.
// The master side offers events and drives dump control; the slave side
// is the accumulator itself.
interface pwr_trans_acum_if #(
    parameter int IDX_W = 4,
    parameter int WGT_W = 8,
    parameter int ACC_W = 32
);
    logic             evt_valid;
    logic [IDX_W-1:0] evt_idx;
    logic [WGT_W-1:0] evt_wgt;
    logic             evt_ready;
    logic             clr;
    logic             dump_start;
    logic             dump_clr;
    logic             dump_valid;
    logic             dump_ready;
    logic [IDX_W-1:0] dump_idx;
    logic [ACC_W-1:0] dump_data;
    logic             dump_last;
    logic             busy;
    logic             ovf;
    logic             err_idx;

    modport master (
        output evt_valid, evt_idx, evt_wgt, clr, dump_start, dump_clr, dump_ready,
        input  evt_ready, dump_valid, dump_idx, dump_data, dump_last, busy, ovf, err_idx
    );

    modport slave (
        input  evt_valid, evt_idx, evt_wgt, clr, dump_start, dump_clr, dump_ready,
        output evt_ready, dump_valid, dump_idx, dump_data, dump_last, busy, ovf, err_idx
    );
endinterface

// File: rtl/pwr_trans_acum.sv
// Power-transition accumulator bank. Events (counter index + weight) are
// buffered in a small FIFO and added into per-index counters while idle;
// a dump streams every counter out with a valid/ready handshake, optionally
// zeroing each one as it is read.
// Optional build macro: PWR_SAT_EN -- counters saturate instead of wrapping.
module pwr_trans_acum #(
    parameter int N_CNTR     = 16,
    parameter int IDX_W      = 4,
    parameter int WGT_W      = 8,
    parameter int ACC_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              reset_L,
    pwr_trans_acum_if.slave  bus
);

    localparam int               CNT_W    = (N_CNTR > 1) ? $clog2(N_CNTR) : 1;
    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W:0]   N_LIM    = (IDX_W+1)'(N_CNTR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CNTR - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, DUMP} state_t;

    state_t           state, next_state;
    logic [IDX_W-1:0] fifo_idx [FIFO_DEPTH];
    logic [WGT_W-1:0] fifo_wgt [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fill;
    logic             full, empty, push, pop;
    logic [ACC_W-1:0] cnt [N_CNTR];
    logic [IDX_W-1:0] ptr;
    logic             dclr;
    logic             ovf, err_idx;
    logic [IDX_W-1:0] pop_idx;
    logic [WGT_W-1:0] pop_wgt;
    logic             pop_bad;
    logic [CNT_W-1:0] pop_sel;
    logic [ACC_W:0]   sum;
    logic             last_word, dump_hs;

    assign full          = (fill == FULL_CNT);
    assign empty         = (fill == '0);
    assign bus.evt_ready = reset_L && !full;
    assign push          = bus.evt_valid && bus.evt_ready;
    // A clear leaves the FIFO untouched, so nothing is popped in that cycle.
    assign pop           = (state == IDLE) && !empty && !bus.clr;
    assign pop_idx       = fifo_idx[rd_ptr];
    assign pop_wgt       = fifo_wgt[rd_ptr];
    assign pop_bad       = ({1'b0, pop_idx} >= N_LIM);
    assign pop_sel       = pop_idx[CNT_W-1:0];
    assign sum           = {1'b0, cnt[pop_sel]} + (ACC_W+1)'(pop_wgt);
    assign last_word     = (ptr == LAST_IDX);
    assign dump_hs       = (state == DUMP) && bus.dump_ready;
    assign bus.ovf       = ovf;
    assign bus.err_idx   = err_idx;

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr] <= bus.evt_idx;
            fifo_wgt[wr_ptr] <= bus.evt_wgt;
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_L) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state and dump output decode; a clear in the same cycle beats a dump start.
    always_comb begin
        next_state     = state;
        bus.dump_valid = 1'b0;
        bus.dump_idx   = '0;
        bus.dump_data  = '0;
        bus.dump_last  = 1'b0;
        bus.busy       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dump_start && !bus.clr) next_state = DUMP;
            end
            DUMP: begin
                bus.dump_valid = 1'b1;
                bus.dump_idx   = ptr;
                bus.dump_data  = cnt[ptr[CNT_W-1:0]];
                bus.dump_last  = last_word;
                bus.busy       = 1'b1;
                if (bus.dump_ready && last_word) next_state = IDLE;
            end
        endcase
    end

    // Dump pointer and the clear-on-read mode latched at dump start.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            ptr  <= '0;
            dclr <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.dump_start && !bus.clr) begin
                ptr  <= '0;
                dclr <= bus.dump_clr;
            end
        end else if (dump_hs && !last_word) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Counters and sticky flags: clear, accumulate from the FIFO, or zero on dump.
    always_ff @(posedge clk) begin
        if (!reset_L || (state == IDLE && bus.clr)) begin
            for (int i = 0; i < N_CNTR; i++) cnt[i] <= '0;
            ovf     <= 1'b0;
            err_idx <= 1'b0;
        end else if (pop) begin
            if (pop_bad) begin
                err_idx <= 1'b1;
            end else if (sum[ACC_W]) begin
                ovf <= 1'b1;
`ifdef PWR_SAT_EN
                cnt[pop_sel] <= '1;
`else
                cnt[pop_sel] <= sum[ACC_W-1:0];
`endif
            end else begin
                cnt[pop_sel] <= sum[ACC_W-1:0];
            end
        end else if (dump_hs && dclr) begin
            cnt[ptr[CNT_W-1:0]] <= '0;
        end
    end

endmodule
